// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states,
// requester IDs and the default abort timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/arb_rr_sel.sv
// Two-way winner selection for mem_arb. Picks the single requester when only
// one is asking; on a tie either alternates (PRIO_RR=1) or favours M0.
// Keeps the registered "last granted" pointer used for alternation.
module arb_rr_sel
    import mem_arb_pkg::*;
#(
    parameter int PRIO_RR = 1
)
(
    input  logic iClk,
    input  logic nRst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_any,
    output logic o_winner
);

    logic r_last;

    // Winner pick: lone requester wins, a tie goes to the port not granted last
    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = ID_M0;
        if (i_req0 && i_req1) begin
            if (PRIO_RR != 0) begin
                o_winner = ~r_last;
            end else begin
                o_winner = ID_M0;
            end
        end else if (i_req1) begin
            o_winner = ID_M1;
        end
    end

    // Last-grant pointer; reset to M1 so M0 takes the first tie
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_last <= ID_M1;
        end else if (i_take) begin
            r_last <= o_winner;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-master single-port memory arbiter (M0 processor, M1 DMA/debug).
// IDLE -> ACCESS -> DONE; one access in flight at a time, completion pulse
// one cycle after leaving ACCESS.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles without iMemRdy (reported through oErrN).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int PRIO_RR        = 1
)
(
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iReq0,
    input  logic        iReq1,
    input  logic        iWrite0,
    input  logic        iWrite1,
    input  logic [31:0] iAddr0,
    input  logic [31:0] iAddr1,
    input  logic [31:0] iWData0,
    input  logic [31:0] iWData1,
    output logic        oGnt0,
    output logic        oGnt1,
    output logic        oRdy0,
    output logic        oRdy1,
    output logic [31:0] oRData0,
    output logic [31:0] oRData1,
    output logic        oErr0,
    output logic        oErr1,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemData,
    input  logic        iMemRdy
);

    state_t      r_state;
    state_t      w_nextState;

    logic        w_anyReq;
    logic        w_winner;
    logic        w_take;
    logic        w_timeout;

    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_rdy0;
    logic        r_rdy1;
    logic [31:0] r_rData0;
    logic [31:0] r_rData1;
    logic [31:0] r_memAddr;
    logic [31:0] r_memData;
    logic        r_memRead;
    logic        r_memWrite;

    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("mem_arb: TIMEOUT_CYCLES must be at least 1");
    end

    assign w_take = (r_state == IDLE) && w_anyReq;

    arb_rr_sel #(
        .PRIO_RR (PRIO_RR)
    ) u_sel (
        .iClk     (iClk),
        .nRst     (nRst),
        .i_req0   (iReq0),
        .i_req1   (iReq1),
        .i_take   (w_take),
        .o_any    (w_anyReq),
        .o_winner (w_winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_waitCnt;
    logic             r_abort;
    logic             r_err0;
    logic             r_err1;

    // The final waiting cycle aborts unless the memory answers in that same cycle
    assign w_timeout = (r_state == ACCESS) && !iMemRdy &&
                       (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter and abort flag; the error bit is released together with oRdyN
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_waitCnt <= '0;
            r_abort   <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_waitCnt <= '0;
                    r_abort   <= 1'b0;
                end
                ACCESS: begin
                    if (!iMemRdy) begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_abort <= 1'b1;
                    end
                end
                DONE: begin
                    r_err0 <= r_abort & r_gnt0;
                    r_err1 <= r_abort & r_gnt1;
                end
                default: begin
                    r_waitCnt <= '0;
                    r_abort   <= 1'b0;
                end
            endcase
        end
    end

    assign oErr0 = r_err0;
    assign oErr1 = r_err1;
`else
    assign w_timeout = 1'b0;
    assign oErr0     = 1'b0;
    assign oErr1     = 1'b0;
`endif

    // State register
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: leave ACCESS on memory completion or abort
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (iMemRdy || w_timeout) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: latch winner's request, capture read data, pulse completion
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rdy0     <= 1'b0;
            r_rdy1     <= 1'b0;
            r_rData0   <= '0;
            r_rData1   <= '0;
            r_memAddr  <= '0;
            r_memData  <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end else begin
            r_rdy0 <= 1'b0;
            r_rdy1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_gnt0 <= (w_winner == ID_M0);
                        r_gnt1 <= (w_winner == ID_M1);
                        if (w_winner == ID_M1) begin
                            r_memAddr  <= iAddr1;
                            r_memData  <= iWData1;
                            r_memRead  <= ~iWrite1;
                            r_memWrite <= iWrite1;
                        end else begin
                            r_memAddr  <= iAddr0;
                            r_memData  <= iWData0;
                            r_memRead  <= ~iWrite0;
                            r_memWrite <= iWrite0;
                        end
                    end
                end
                ACCESS: begin
                    if (iMemRdy && r_memRead) begin
                        if (r_gnt1) begin
                            r_rData1 <= iMemData;
                        end else begin
                            r_rData0 <= iMemData;
                        end
                    end
                end
                DONE: begin
                    r_rdy0     <= r_gnt0;
                    r_rdy1     <= r_gnt1;
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_memRead  <= 1'b0;
                    r_memWrite <= 1'b0;
                end
                default: begin
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_memRead  <= 1'b0;
                    r_memWrite <= 1'b0;
                end
            endcase
        end
    end

    assign oGnt0     = r_gnt0;
    assign oGnt1     = r_gnt1;
    assign oRdy0     = r_rdy0;
    assign oRdy1     = r_rdy1;
    assign oRData0   = r_rData0;
    assign oRData1   = r_rData1;
    assign oMemAddr  = r_memAddr;
    assign oMemData  = r_memData;
    assign oMemRead  = r_memRead;
    assign oMemWrite = r_memWrite;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb. The bench plays the memory, keeps a
// transaction-level model (who was granted last, last read word per port)
// and checks grants, strobes, completion timing and read data.
// Timeout steps are built only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arb;

    localparam int TB_PRIO_RR = 1;
    localparam int TB_TIMEOUT = 16;

    logic        iClk;
    logic        nRst;
    logic        iReq0, iReq1;
    logic        iWrite0, iWrite1;
    logic [31:0] iAddr0, iAddr1, iWData0, iWData1;
    logic        oGnt0, oGnt1, oRdy0, oRdy1, oErr0, oErr1;
    logic [31:0] oRData0, oRData1, oMemAddr, oMemData;
    logic        oMemRead, oMemWrite;
    logic [31:0] iMemData;
    logic        iMemRdy;

    int          testCount = 0;
    int          failCount = 0;

    logic        modelLast;
    logic [31:0] modelRData [2];

    mem_arb #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .PRIO_RR        (TB_PRIO_RR)
    ) dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iReq0     (iReq0),
        .iReq1     (iReq1),
        .iWrite0   (iWrite0),
        .iWrite1   (iWrite1),
        .iAddr0    (iAddr0),
        .iAddr1    (iAddr1),
        .iWData0   (iWData0),
        .iWData1   (iWData1),
        .oGnt0     (oGnt0),
        .oGnt1     (oGnt1),
        .oRdy0     (oRdy0),
        .oRdy1     (oRdy1),
        .oRData0   (oRData0),
        .oRData1   (oRData1),
        .oErr0     (oErr0),
        .oErr1     (oErr1),
        .oMemAddr  (oMemAddr),
        .oMemData  (oMemData),
        .oMemRead  (oMemRead),
        .oMemWrite (oMemWrite),
        .iMemData  (iMemData),
        .iMemRdy   (iMemRdy)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkOutput(tag, 32'(observed), 32'(expected));
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Arbitration rule: lone requester wins; tie goes to the other port than last time
    function automatic logic pickWinner(input logic r0, input logic r1);
        if (r0 && r1) begin
            return (TB_PRIO_RR != 0) ? ~modelLast : 1'b0;
        end
        return r1 && !r0;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctl"}, 32'({oGnt0, oGnt1, oRdy0, oRdy1, oErr0, oErr1, oMemRead, oMemWrite}), 32'd0);
        checkOutput({tag, "_addr"}, oMemAddr, 32'd0);
        checkOutput({tag, "_wdata"}, oMemData, 32'd0);
        checkOutput({tag, "_rdata0"}, oRData0, 32'd0);
        checkOutput({tag, "_rdata1"}, oRData1, 32'd0);
    endtask

    // One full access: request in IDLE, memory answers after 'latency' wait cycles
    task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input int latency, input logic [31:0] memWord, input logic dropReq);
        logic        win;
        logic        wr;
        logic [31:0] expAddr;
        logic [31:0] expData;
        iReq0 = r0;  iReq1 = r1;
        iWrite0 = w0; iWrite1 = w1;
        iAddr0 = a0; iAddr1 = a1;
        iWData0 = d0; iWData1 = d1;
        win     = pickWinner(r0, r1);
        wr      = win ? w1 : w0;
        expAddr = win ? a1 : a0;
        expData = win ? d1 : d0;
        tick();
        modelLast = win;
        if (dropReq) begin
            iReq0 = 1'b0;
            iReq1 = 1'b0;
        end
        for (int c = 0; c <= latency; c++) begin
            if (c == latency) begin
                iMemRdy  = 1'b1;
                iMemData = memWord;
            end
            checkBit("gnt0", oGnt0, ~win);
            checkBit("gnt1", oGnt1, win);
            checkBit("memRead", oMemRead, ~wr);
            checkBit("memWrite", oMemWrite, wr);
            checkOutput("memAddr", oMemAddr, expAddr);
            if (wr) checkOutput("memData", oMemData, expData);
            checkOutput("rdyEarly", 32'({oRdy0, oRdy1}), 32'd0);
            tick();
        end
        iMemRdy  = 1'b0;
        iMemData = $urandom;
        checkOutput("rdyInDone", 32'({oRdy0, oRdy1}), 32'd0);
        tick();
        if (!wr) modelRData[win] = memWord;
        checkBit("rdy0", oRdy0, ~win);
        checkBit("rdy1", oRdy1, win);
        checkOutput("errDone", 32'({oErr0, oErr1}), 32'd0);
        checkOutput("gntIdle", 32'({oGnt0, oGnt1}), 32'd0);
        checkOutput("strobeIdle", 32'({oMemRead, oMemWrite}), 32'd0);
        checkOutput("rdata0", oRData0, modelRData[0]);
        checkOutput("rdata1", oRData1, modelRData[1]);
    endtask

    initial begin
        nRst = 1'b0;
        iReq0 = 1'b0; iReq1 = 1'b0; iWrite0 = 1'b0; iWrite1 = 1'b0;
        iAddr0 = '0; iAddr1 = '0; iWData0 = '0; iWData1 = '0;
        iMemData = '0; iMemRdy = 1'b0;
        modelLast = 1'b1;
        modelRData[0] = '0;
        modelRData[1] = '0;

        #12;
        checkAllZero("reset");
        @(negedge iClk);
        nRst = 1'b1;

        $display("[TB] single read from M0");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 3, 32'hDEADBEEF, 1'b1);
        checkOutput("singleRead", oRData0, 32'hDEADBEEF);

        $display("[TB] write from M1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 32'h55AA55AA, 2, 32'h12345678, 1'b1);
        checkOutput("writeKeepsRData1", oRData1, 32'h0);

        $display("[TB] contention with both held");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000 + k, 32'h2000 + k, 32'h0, 32'h0, k % 2, $urandom, 1'b0);
            checkBit("alternation", oRdy1, 1'(k % 2));
        end
        iReq0 = 1'b0;
        iReq1 = 1'b0;

        $display("[TB] reset in the middle of an access");
        iReq0 = 1'b1; iWrite0 = 1'b0; iAddr0 = 32'h300;
        tick();
        iReq0 = 1'b0;
        tick();
        #2;
        nRst = 1'b0;
        #1;
        checkAllZero("asyncReset");
        tick();
        checkOutput("noRdyAfterReset", 32'({oRdy0, oRdy1}), 32'd0);
        modelLast     = 1'b1;
        modelRData[0] = '0;
        modelRData[1] = '0;
        @(negedge iClk);
        nRst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h80, 32'h0, 32'h0, 1, 32'hCAFE0001, 1'b1);
        checkBit("firstTieM0", oRdy0, 1'b1);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            logic [1:0] req;
            req = 2'($urandom_range(1, 3));
            applyStimulus(req[0], req[1], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                          $urandom_range(0, 4), $urandom, 1'($urandom));
        end
        iReq0 = 1'b0;
        iReq1 = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] timeout abort");
        iReq0 = 1'b1; iWrite0 = 1'b0; iAddr0 = 32'h500;
        tick();
        iReq0 = 1'b0;
        for (int c = 1; c <= TB_TIMEOUT + 1; c++) begin
            checkBit("noRdyBeforeTimeout", oRdy0, 1'b0);
            tick();
        end
        modelLast = 1'b0;
        checkBit("timeoutRdy0", oRdy0, 1'b1);
        checkBit("timeoutErr0", oErr0, 1'b1);
        checkOutput("timeoutRData0", oRData0, modelRData[0]);
        checkOutput("timeoutGnt", 32'({oGnt0, oGnt1}), 32'd0);
        tick();
        checkOutput("errCleared", 32'({oErr0, oRdy0}), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h504, 32'h0, 32'h0, 32'h0, 0, 32'hA5A5A5A5, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h508, 32'h0, 32'h0, TB_TIMEOUT - 1, 32'h0BADF00D, 1'b1);
`else
        $display("[TB] long wait without timeout");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0, TB_TIMEOUT + 8, 32'h600D600D, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, memory wait cycles before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 Parameter PRIO_RR, default 1, 1 = round-robin tie-break, 0 = fixed priority to M0.
REQ-003 iClk  in  1  single clock, all state changes on rising edge.
REQ-004 nRst  in  1  asynchronous active-low reset.
REQ-005 iReq0/iReq1  in  1  access request from M0 (processor) / M1 (DMA/debug).
REQ-006 iWrite0/iWrite1  in  1  1 = write, 0 = read, valid with iReqN.
REQ-007 iAddr0/iAddr1, iWData0/iWData1  in  32  address / write data, valid with iReqN.
REQ-008 oGnt0/oGnt1  out  1  high while the arbiter's memory access belongs to that requester.
REQ-009 oRdy0/oRdy1  out  1  one-cycle completion pulse.
REQ-010 oRData0/oRData1  out  32  read data, valid in the oRdyN cycle, held until the next completion for that port.
REQ-011 oErr0/oErr1  out  1  abort flag, valid in the oRdyN cycle.
REQ-012 oMemAddr, oMemData  out  32  memory address / write data.
REQ-013 oMemRead, oMemWrite  out  1  memory strobes, mutually exclusive.
REQ-014 iMemData  in  32  memory read data; iMemRdy  in  1  memory completion.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE.
REQ-016 IDLE: if any iReqN=1, pick the winner, register its addr/wdata/write into oMemAddr/oMemData/strobe, set oGntN, go to ACCESS.
REQ-017 Tie (both requesting, PRIO_RR=1): grant the port not granted last; PRIO_RR=0: M0 wins.
REQ-018 ACCESS: hold address, data and strobe constant; on iMemRdy=1, capture iMemData into oRDataN (reads only), go to DONE.
REQ-019 DONE: pulse oRdyN for exactly one cycle, drop strobes and oGntN, return to IDLE; re-arbitration occurs in the following IDLE cycle.
REQ-020 Latency: request seen at edge 0 -> strobe high after edge 0 -> with iMemRdy high in the first ACCESS cycle, oRdyN high after edge 2.
REQ-021 Write completion does not modify oRDataN.
REQ-022 A request dropped mid-access does not cancel it; the access completes and oRdyN still pulses.
REQ-023 Requests arriving during ACCESS or DONE wait; there is no queueing beyond the held iReqN level.
REQ-024 Exactly one oGntN is high at a time; both are low in IDLE.
REQ-025 The last-granted pointer updates only on a grant in IDLE.

Reset
REQ-026 nRst low forces IDLE immediately, regardless of clock.
REQ-027 Reset values: all strobes, oGntN, oRdyN, oErrN = 0; oMemAddr, oMemData, oRDataN = 0.
REQ-028 Reset sets the pointer so that M0 wins the first tie.
REQ-029 Reset during ACCESS abandons the access with no oRdyN pulse.

Configuration
REQ-030 MEM_ARB_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without iMemRdy.
REQ-031 With MEM_ARB_TIMEOUT_EN, on reaching TIMEOUT_CYCLES the access aborts: go to DONE, oRDataN unchanged, oErrN=1 with oRdyN.
REQ-032 iMemRdy in the same cycle as the timeout takes precedence, giving a normal completion with oErrN=0.
REQ-033 MEM_ARB_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, oErrN tied 0 (ports remain).

Structure
REQ-034 Package mem_arb_pkg holds the FSM state typedef, the requester ID constants (M0=0, M1=1) and the default TIMEOUT_CYCLES constant.
REQ-035 Sub-module arb_rr_sel holds the combinational 2-way winner pick plus the registered last-grant pointer; the FSM, the datapath registers and the timeout counter stay in mem_arb.

Verification
REQ-036 Single read: M0 reads 0x100, memory returns 0xDEADBEEF with iMemRdy after 3 wait cycles -> oRdy0 pulse, oRData0=0xDEADBEEF, oErr0=0.
REQ-037 Contention: both request continuously -> grants alternate M0, M1, M0, M1 (PRIO_RR=1); PRIO_RR=0 -> M0 only.
REQ-038 Write: M1 writes 0x55AA55AA to 0x200 -> oMemWrite with those values held until iMemRdy, oRData1 unchanged.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=16): iMemRdy never asserted -> oRdy0 and oErr0 high on cycle 17, next request granted normally.
REQ-040 Reset mid-ACCESS: nRst low -> all outputs 0 asynchronously, no oRdy pulse, first tie after release goes to M0.
